alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Execute-stage sequencer wrapped around the combinational 8-bit ALU.
- Owns the AC, R and Z registers and accepts one 4-bit opcode at a time through a valid/ready handshake.
- Drives the ALU operand and select lines (alu_ac, alu_bus, alu_sel), writes alu_result back into AC/R/Z, and pulses done on completion.
- Sits between instruction decode (upstream) and the ALU (downstream/loop-back).

Parameters:
- DW, 8, datapath width of AC, R, operand and ALU ports.
- OPW, 4, opcode width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- op_valid  in  1  opcode/operand present.
- op_ready  out  1  block can accept an op (high only in IDLE).
- opcode  in  OPW  operation code; captured on handshake.
- operand  in  DW  external data for LDAC/LDR; captured on handshake.
- alu_sel  out  7  ALUSEL[7:1] to ALU.
- alu_ac  out  DW  AC_in to ALU (always the AC register).
- alu_bus  out  DW  bus_in to ALU.
- alu_result  in  DW  ALU_out from ALU.
- ac_q  out  DW  AC register.
- r_q  out  DW  R register.
- z_q  out  1  zero flag.
- done  out  1  one-cycle pulse when the op has retired.
- illegal  out  1  one-cycle pulse when an undefined opcode is handshaked.

Behaviour:
- Reset (rst_n low at a clk edge): AC=0, R=0, Z=0, state=IDLE.
  - Outputs after reset: done=0, illegal=0, alu_sel=0, alu_bus=0, op_ready=1.
  - Reset wins over every other event, including mid-op; any op in flight is abandoned without writeback.
- States: IDLE, EXEC, RETIRE.
- IDLE:
  - op_ready=1, alu_sel=0, alu_bus=0.
  - On op_valid&op_ready, latch opcode→op_q and operand→opd_q.
  - Legal opcode: go to EXEC. Undefined opcode: illegal=1 next cycle, stay IDLE.
- EXEC (exactly 1 cycle):
  - op_ready=0; drive alu_sel/alu_bus per op_q.
  - At the closing edge, write back alu_result to the destination; go to RETIRE.
- RETIRE (1 cycle):
  - done=1, op_ready=0; go to IDLE.
  - A new op may be handshaked the cycle after done.
- Throughput: one op per 3 cycles. Latency from handshake edge to result visible on ac_q/r_q/z_q: 2 edges.
- Opcode table, as opcode: op, alu_sel[7:1], alu_bus, destination:
  - 0000: NOP, 0000000, 0, none (still runs EXEC/RETIRE, done pulses).
  - 0001: LDAC, 0000100, opd_q, AC.
  - 0010: LDR, 0000100, opd_q, R.
  - 0011: MVAC, 0000100, AC, R (R←AC via ALU pass-through).
  - 0100: MOVR, 0000100, R, AC.
  - 1000: ADD, 0000101, R, AC+Z.
  - 1001: SUB, 0001011, R, AC+Z.
  - 1010: INAC, 0001001, 0, AC+Z.
  - 1011: CLAC, 0000000, 0, AC+Z.
  - 1100: AND, 1000000, R, AC+Z.
  - 1101: OR, 1100000, R, AC+Z.
  - 1110: XOR, 1010000, R, AC+Z.
  - 1111: NOT, 1110000, 0, AC+Z.
  - 0101–0111: undefined.
- Z update: Z ← (alu_result == 0) only for opcodes 1xxx. Z is unchanged by LDAC/LDR/MVAC/MOVR/NOP.
- Arithmetic wraps modulo 2^DW; carry is discarded.
- op_valid/opcode changes while not in IDLE are ignored; upstream holds op_valid until op_ready is seen.

Optional Feature:
- Macro ALU_EXEC_NFLAG_EN.
- Defined: adds output n_q (1 bit, reset 0). n_q ← alu_result[DW-1] on the same writes as Z.
- Undefined: port n_q is absent, with no other change.

Test Plan:
- Reset then idle → ac_q=0, r_q=0, z_q=0, op_ready=1, done=0; assert rst_n low mid-EXEC → no writeback, all regs 0 next cycle.
- LDAC 0x7F, LDR 0x01, ADD → ac_q=0x80, z_q=0; done pulses exactly once per op, 2 cycles after each handshake.
- LDAC 0x05, LDR 0x05, SUB → ac_q=0x00, z_q=1; then INAC → ac_q=0x01, z_q=0.
- LDAC 0xFF, INAC → ac_q=0x00 (wrap), z_q=1; alu_sel=0001001 observed during EXEC.
- LDAC 0xF0, LDR 0x3C: AND→0x30; OR (reload AC 0xF0)→0xFC; XOR (reload)→0xCC; NOT (reload)→0x0F; Z stays 0 throughout; MVAC then MOVR round-trips AC.
- Opcode 0110 with op_valid → illegal=1 for one cycle, done=0, registers unchanged; op_valid held during EXEC is not accepted until IDLE.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage sequencer around the combinational 8-bit ALU
//
// Owns AC, R and Z. Accepts one opcode per valid/ready handshake.
// Sequence: IDLE -> EXEC (ALU driven, writeback at closing edge) -> RETIRE (done) -> IDLE.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   op_valid, op_ready  opcode handshake (op_ready high only in IDLE)
//   opcode, operand     op code and external data for LDAC/LDR, captured on handshake
//   alu_sel, alu_ac,    select lines and operands to the ALU (alu_ac is always AC)
//   alu_bus
//   alu_result          ALU output looped back for writeback
//   ac_q, r_q, z_q      architectural registers
//   done                one-cycle pulse when an op retires
//   illegal             one-cycle pulse when an undefined opcode is handshaked
//   n_q                 negative flag, present only when ALU_EXEC_NFLAG_EN is defined
//
// Optional feature macro: ALU_EXEC_NFLAG_EN
module alu_exec_ctrl #(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [DW-1:0]  operand,
  output logic [6:0]     alu_sel,
  output logic [DW-1:0]  alu_ac,
  output logic [DW-1:0]  alu_bus,
  input  logic [DW-1:0]  alu_result,
  output logic [DW-1:0]  ac_q,
  output logic [DW-1:0]  r_q,
  output logic           z_q,
`ifdef ALU_EXEC_NFLAG_EN
  output logic           n_q,
`endif
  output logic           done,
  output logic           illegal
);

  localparam logic [OPW-1:0] OP_NOP  = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_LDAC = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_LDR  = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_MVAC = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_MOVR = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_INAC = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_CLAC = OPW'(4'b1011);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'b1100);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'b1101);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(4'b1111);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t         state;
  logic [OPW-1:0] op_q;

  logic           dec_legal;
  logic [6:0]     dec_sel;
  logic [DW-1:0]  dec_bus;

  assign alu_ac = ac_q;

  // Decode the incoming opcode so alu_sel/alu_bus can be registered at the
  // handshake edge and are stable for the whole EXEC cycle. AC/R cannot change
  // while in IDLE, so sampling them here for MVAC/MOVR is safe.
  always_comb begin
    dec_legal = 1'b1;
    dec_sel   = 7'b0000000;
    dec_bus   = '0;
    case (opcode)
      OP_NOP: begin
        dec_sel = 7'b0000000;
      end
      OP_LDAC, OP_LDR: begin
        dec_sel = 7'b0000100;
        dec_bus = operand;
      end
      OP_MVAC: begin
        dec_sel = 7'b0000100;
        dec_bus = ac_q;
      end
      OP_MOVR: begin
        dec_sel = 7'b0000100;
        dec_bus = r_q;
      end
      OP_ADD: begin
        dec_sel = 7'b0000101;
        dec_bus = r_q;
      end
      OP_SUB: begin
        dec_sel = 7'b0001011;
        dec_bus = r_q;
      end
      OP_INAC: begin
        dec_sel = 7'b0001001;
      end
      OP_CLAC: begin
        dec_sel = 7'b0000000;
      end
      OP_AND: begin
        dec_sel = 7'b1000000;
        dec_bus = r_q;
      end
      OP_OR: begin
        dec_sel = 7'b1100000;
        dec_bus = r_q;
      end
      OP_XOR: begin
        dec_sel = 7'b1010000;
        dec_bus = r_q;
      end
      OP_NOT: begin
        dec_sel = 7'b1110000;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      ac_q     <= '0;
      r_q      <= '0;
      z_q      <= 1'b0;
`ifdef ALU_EXEC_NFLAG_EN
      n_q      <= 1'b0;
`endif
      alu_sel  <= 7'b0000000;
      alu_bus  <= '0;
      op_ready <= 1'b1;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q <= opcode;
            if (dec_legal) begin
              state    <= EXEC;
              op_ready <= 1'b0;
              alu_sel  <= dec_sel;
              alu_bus  <= dec_bus;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          // Destination: AC for LDAC/MOVR, R for LDR/MVAC, AC plus flags for 1xxx.
          case (op_q)
            OP_LDAC, OP_MOVR: ac_q <= alu_result;
            OP_LDR, OP_MVAC:  r_q  <= alu_result;
            default: begin
              if (op_q[OPW-1]) begin
                ac_q <= alu_result;
                z_q  <= (alu_result == '0);
`ifdef ALU_EXEC_NFLAG_EN
                n_q  <= alu_result[DW-1];
`endif
              end
            end
          endcase
          alu_sel <= 7'b0000000;
          alu_bus <= '0;
          done    <= 1'b1;
          state   <= RETIRE;
        end
        RETIRE: begin
          op_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          op_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
